// File: rtl/mvm_seq_pkg.sv
// Shared types and constants for the ping-pong matrix-vector sequencer.
package mvm_seq_pkg;

  // Compute-side phases for one output row.
  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    DRAIN,
    LATCH,
    OUT
  } state_t;

  // Tag travelling alongside each issued x/W read so the accumulator knows
  // whether the arriving product starts a new row or extends the current one.
  typedef struct packed {
    logic valid;
    logic first;
  } issue_tag_t;

  localparam int DEF_M      = 4;
  localparam int DEF_N      = 8;
  localparam int DEF_RD_LAT = 2;

  // Address width for n locations, never narrower than one bit.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mvm_issue_delay.sv
// Fixed-latency shift register aligning issue tags with products arriving
// at the accumulator.
module mvm_issue_delay
  import mvm_seq_pkg::*;
#(
  parameter int DEPTH = DEF_RD_LAT
) (
  input  logic       clk,
  input  logic       reset,
  input  issue_tag_t tag_in,
  output issue_tag_t tag_out
);

  issue_tag_t stage_reg [DEPTH];

  // Shift tags one stage per cycle; reset empties the pipe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_reg[i] <= '0;
      end
    end else begin
      stage_reg[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) begin
        stage_reg[i] <= stage_reg[i-1];
      end
    end
  end

  assign tag_out = stage_reg[DEPTH-1];

endmodule

// File: rtl/mvm_pingpong_sequencer.sv
// Control sequencer for a single-MAC matrix-vector layer with a ping-pong
// x buffer: one bank fills from upstream while the other feeds the MAC.
module mvm_pingpong_sequencer
  import mvm_seq_pkg::*;
#(
  parameter int M      = DEF_M,
  parameter int N      = DEF_N,
  parameter int RD_LAT = DEF_RD_LAT,
  localparam int AW_X  = $clog2(N) + 1,
  localparam int WAW   = width_of(M * N),
  localparam int BAW   = width_of(M)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_valid,
  output logic            s_ready,
  output logic            x_wr_en,
  output logic [AW_X-1:0] x_wr_addr,
  output logic [AW_X-1:0] x_rd_addr,
  output logic [WAW-1:0]  w_addr,
  output logic [BAW-1:0]  b_addr,
  output logic            acc_load,
  output logic            acc_en,
  output logic            out_latch,
  output logic            m_valid,
  input  logic            m_ready,
  output logic            busy
);

  localparam int CW = AW_X - 1;
  localparam int DW = width_of(RD_LAT);

  // Load side
  logic [1:0]    bank_full_reg, bank_full_next;
  logic          wr_bank_reg, wr_bank_next;
  logic [CW-1:0] wr_ptr_reg, wr_ptr_next;
  logic          accept;

  // Compute side
  state_t        state_reg, state_next;
  logic          rd_bank_reg, rd_bank_next;
  logic [BAW-1:0] row_reg, row_next;
  logic [CW-1:0] col_reg, col_next;
  logic [DW-1:0] drain_reg, drain_next;
  logic          release_bank;

  issue_tag_t    push_tag, tag_out;

  assign s_ready   = !bank_full_reg[wr_bank_reg];
  assign accept    = s_valid && s_ready;
  assign x_wr_en   = accept;
  assign x_wr_addr = {wr_bank_reg, wr_ptr_reg};

  // Addresses follow row/col directly, so they naturally hold while stalled.
  assign x_rd_addr = {rd_bank_reg, col_reg};
  assign w_addr    = WAW'(row_reg) * WAW'(N) + WAW'(col_reg);
  assign b_addr    = row_reg;
  assign busy      = (state_reg != IDLE);

  assign acc_load  = tag_out.valid && tag_out.first;
  assign acc_en    = tag_out.valid && !tag_out.first;

  // Fill pointer and bank occupancy; a release and a fill always target
  // different banks, so both may land in the same cycle.
  always_comb begin
    bank_full_next = bank_full_reg;
    wr_bank_next   = wr_bank_reg;
    wr_ptr_next    = wr_ptr_reg;
    if (release_bank) begin
      bank_full_next[rd_bank_reg] = 1'b0;
    end
    if (accept) begin
      if (wr_ptr_reg == CW'(N - 1)) begin
        bank_full_next[wr_bank_reg] = 1'b1;
        wr_bank_next                = ~wr_bank_reg;
        wr_ptr_next                 = '0;
      end else begin
        wr_ptr_next = wr_ptr_reg + CW'(1);
      end
    end
  end

  // Register the load-side state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bank_full_reg <= 2'b00;
      wr_bank_reg   <= 1'b0;
      wr_ptr_reg    <= '0;
    end else begin
      bank_full_reg <= bank_full_next;
      wr_bank_reg   <= wr_bank_next;
      wr_ptr_reg    <= wr_ptr_next;
    end
  end

  // Compute FSM: next state, counters, issue tag and output strobes.
  always_comb begin
    state_next   = state_reg;
    row_next     = row_reg;
    col_next     = col_reg;
    drain_next   = drain_reg;
    rd_bank_next = rd_bank_reg;
    release_bank = 1'b0;
    push_tag     = '0;
    out_latch    = 1'b0;
    m_valid      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bank_full_reg[rd_bank_reg]) begin
          row_next   = '0;
          col_next   = '0;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        push_tag.valid = 1'b1;
        push_tag.first = (col_reg == '0);
        // col parks on the last column so addresses stay put until the row ends.
        if (col_reg == CW'(N - 1)) begin
          drain_next = '0;
          state_next = DRAIN;
        end else begin
          col_next = col_reg + CW'(1);
        end
      end
      DRAIN: begin
        if (drain_reg == DW'(RD_LAT - 1)) begin
          state_next = LATCH;
        end else begin
          drain_next = drain_reg + DW'(1);
        end
      end
      LATCH: begin
        out_latch  = 1'b1;
        state_next = OUT;
      end
      OUT: begin
        m_valid = 1'b1;
        if (m_ready) begin
          if (row_reg == BAW'(M - 1)) begin
            release_bank = 1'b1;
            rd_bank_next = ~rd_bank_reg;
            state_next   = IDLE;
          end else begin
            row_next   = row_reg + BAW'(1);
            col_next   = '0;
            state_next = ISSUE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Register the compute-side state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      rd_bank_reg <= 1'b0;
      row_reg     <= '0;
      col_reg     <= '0;
      drain_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      rd_bank_reg <= rd_bank_next;
      row_reg     <= row_next;
      col_reg     <= col_next;
      drain_reg   <= drain_next;
    end
  end

  mvm_issue_delay #(
    .DEPTH(RD_LAT)
  ) u_issue_delay (
    .clk    (clk),
    .reset  (reset),
    .tag_in (push_tag),
    .tag_out(tag_out)
  );

endmodule

// File: tb/tb_mvm_pingpong_sequencer.sv
// Bench for mvm_pingpong_sequencer: phase-count reference model checked every
// cycle, a small datapath driven by the DUT's strobes, and a y scoreboard
// computed directly from the loaded vectors.
module tb_mvm_pingpong_sequencer;

  localparam int M = 4, N = 8, RD_LAT = 2;
  localparam int AW_X = 4, WAW = 5, BAW = 2;
  localparam int PL = N + RD_LAT;   // phase of the latch cycle within a row

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic s_valid = 1'b0;
  logic m_ready = 1'b1;
  logic s_ready, x_wr_en, acc_load, acc_en, out_latch, m_valid, busy;
  logic [AW_X-1:0] x_wr_addr, x_rd_addr;
  logic [WAW-1:0]  w_addr;
  logic [BAW-1:0]  b_addr;
  int s_data = 0;

  always #5 clk = ~clk;

  mvm_pingpong_sequencer #(.M(M), .N(N), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready),
    .x_wr_en(x_wr_en), .x_wr_addr(x_wr_addr), .x_rd_addr(x_rd_addr),
    .w_addr(w_addr), .b_addr(b_addr), .acc_load(acc_load), .acc_en(acc_en),
    .out_latch(out_latch), .m_valid(m_valid), .m_ready(m_ready), .busy(busy)
  );

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Team weight ROM: rows 0..2 hold c-r, row 3 is uniformly -3.
  function automatic int w_rom(input int a);
    int r, c;
    r = a / N;
    c = a % N;
    return (r == 3) ? -3 : (c - r);
  endfunction

  function automatic int b_rom(input int r);
    case (r)
      0: return 5;
      1: return -2;
      2: return 3;
      default: return 1;
    endcase
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Datapath driven purely by the sequencer's addresses and strobes.
  int xbuf [2*N];
  int wq = 0, xq = 0, prod = 0, acc = 0, y_reg = 0;
  always @(posedge clk) begin
    if (x_wr_en) xbuf[x_wr_addr] <= s_data;
    wq   <= w_rom(int'(w_addr));
    xq   <= xbuf[x_rd_addr];
    prod <= wq * xq;
    if (acc_load) acc <= b_rom(int'(b_addr)) + prod;
    else if (acc_en) acc <= acc + prod;
    if (out_latch) y_reg <= (acc < 0) ? 0 : acc;
  end

  // Reference model: bank occupancy plus a phase count p within each row.
  bit m_full [2];
  int m_wb, m_wp, m_rb, m_row, m_p;
  bit m_active, m_acc;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_full[0] = 0; m_full[1] = 0;
      m_wb = 0; m_wp = 0; m_rb = 0; m_row = 0; m_p = 0; m_active = 0;
    end else begin
      m_acc = s_valid && !m_full[m_wb];
      if (!m_active) begin
        if (m_full[m_rb]) begin m_active = 1; m_row = 0; m_p = 0; end
      end else if (m_p < PL + 1) begin
        m_p++;
      end else if (m_ready) begin
        if (m_row == M - 1) begin m_active = 0; m_full[m_rb] = 0; m_rb ^= 1; end
        else begin m_row++; m_p = 0; end
      end
      if (m_acc) begin
        if (m_wp == N - 1) begin m_full[m_wb] = 1; m_wb ^= 1; m_wp = 0; end
        else m_wp++;
      end
    end
  end

  // Scoreboard and event logs (cleared by reset).
  int cur_vec[$];
  int exp_y[$];
  int hs_rows[$], hs_banks[$], hs_cyc[$], rise_cyc[$];
  int n_acc_seen = 0, stall_at = -1;
  bit prev_rdy = 1;

  // Per-cycle compare against the model, plus y scoreboard on handshakes.
  always @(negedge clk) begin : cmp
    int col_e;
    col_e = (m_p < N) ? m_p : N - 1;
    check("s_ready", int'(s_ready), int'(!m_full[m_wb]));
    check("x_wr_en", int'(x_wr_en), int'(s_valid && !m_full[m_wb]));
    if (x_wr_en) check("x_wr_addr", int'(x_wr_addr), m_wb * N + m_wp);
    check("busy", int'(busy), int'(m_active));
    check("m_valid", int'(m_valid), int'(m_active && m_p == PL + 1));
    check("acc_load", int'(acc_load), int'(m_active && m_p == RD_LAT));
    check("acc_en", int'(acc_en), int'(m_active && m_p > RD_LAT && m_p < PL));
    check("out_latch", int'(out_latch), int'(m_active && m_p == PL));
    if (m_active) begin
      check("w_addr", int'(w_addr), m_row * N + col_e);
      check("x_rd_addr", int'(x_rd_addr), m_rb * N + col_e);
      check("b_addr", int'(b_addr), m_row);
    end
    if (reset) begin
      cur_vec.delete(); exp_y.delete(); hs_rows.delete(); hs_banks.delete();
      hs_cyc.delete(); rise_cyc.delete();
      n_acc_seen = 0; stall_at = -1; prev_rdy = 1;
    end else begin
      if (s_valid && !s_ready && stall_at < 0) stall_at = n_acc_seen;
      if (x_wr_en) begin
        n_acc_seen++;
        cur_vec.push_back(s_data);
        if (cur_vec.size() == N) begin
          for (int r = 0; r < M; r++) begin
            int s;
            s = b_rom(r);
            for (int c = 0; c < N; c++) s += w_rom(r * N + c) * cur_vec[c];
            exp_y.push_back((s < 0) ? 0 : s);
          end
          cur_vec.delete();
        end
      end
      if (m_valid && m_ready) begin
        if (exp_y.size() == 0) check("y_unexpected", 1, 0);
        else check("y_value", y_reg, exp_y.pop_front());
        hs_rows.push_back(int'(b_addr));
        hs_banks.push_back(int'(x_rd_addr[AW_X-1]));
        hs_cyc.push_back(cyc);
      end
      if (s_ready && !prev_rdy) rise_cyc.push_back(cyc);
      prev_rdy = s_ready;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1; s_valid = 0; m_ready = 1;
    @(negedge clk);
    tick();
    reset = 0;
  endtask

  task automatic send(input int d, input int gap);
    bit done;
    done = 0;
    s_valid = 1; s_data = d;
    for (int n = 0; n < 600 && !done; n++) begin
      @(negedge clk);
      done = s_ready;
      tick();
    end
    if (!done) check("send_timeout", 0, 1);
    s_valid = 0;
    repeat (gap) tick();
  endtask

  task automatic wait_idle();
    int quiet;
    quiet = 0;
    for (int n = 0; n < 3000 && quiet < 4; n++) begin
      @(negedge clk);
      quiet = (busy || s_valid) ? 0 : quiet + 1;
      tick();
    end
    if (quiet < 4) check("idle_timeout", 0, 1);
  endtask

  function automatic int rnd_x();
    return int'($urandom_range(0, 40)) - 20;
  endfunction

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int t_acc, t_lat, t_mv, t_hs, nhs, n_en, w_last;
    int ys [4];
    int npulse;
    bit found;

    // ---- reset state ----
    #2;
    check("rst_s_ready", int'(s_ready), 1);
    check("rst_m_valid", int'(m_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_strobes", int'(acc_load | acc_en | out_latch), 0);
    do_reset();

    // ---- single vector of ones, literal timing ----
    for (int i = 0; i < N - 1; i++) send(1, 0);
    s_valid = 1; s_data = 1;
    t_acc = -1; t_lat = -1; t_mv = -1; t_hs = -1; nhs = 0; n_en = 0; w_last = -1;
    for (int rel = 0; rel < 60; rel++) begin
      @(negedge clk);
      if (rel == 0) check("t1_ready_c0", int'(s_ready), 1);
      if (rel == 9) w_last = int'(w_addr);
      if (acc_load && t_acc < 0) t_acc = rel;
      if (out_latch && t_lat < 0) t_lat = rel;
      if (m_valid && t_mv < 0) t_mv = rel;
      if (acc_en && rel <= 12) n_en++;
      if (m_valid && m_ready) begin
        if (nhs < 4) ys[nhs] = y_reg;
        nhs++;
        t_hs = rel;
      end
      tick();
      s_valid = 0;
    end
    check("t1_acc_load_cyc", t_acc, 4);
    check("t1_acc_en_count", n_en, 7);
    check("t1_w_addr_c9", w_last, 7);
    check("t1_latch_cyc", t_lat, 12);
    check("t1_m_valid_cyc", t_mv, 13);
    check("t1_last_hs_cyc", t_hs, 49);
    check("t1_hs_count", nhs, 4);
    check("t1_y0", ys[0], 33);
    check("t1_y1", ys[1], 18);
    check("t1_y2", ys[2], 15);
    check("t1_y3_clamped", ys[3], 0);
    wait_idle();

    // ---- ping-pong: 24 elements back to back ----
    do_reset();
    for (int i = 0; i < 3 * N; i++) send(rnd_x(), 0);
    wait_idle();
    check("pp_stall_after", stall_at, 16);
    check("pp_hs_count", hs_cyc.size(), 12);
    if (hs_cyc.size() == 12) begin
      check("pp_bank_v0", hs_banks[0], 0);
      check("pp_bank_v1", hs_banks[4], 1);
      check("pp_bank_v2", hs_banks[8], 0);
      check("pp_rise_after_hs4", (rise_cyc.size() > 0) ? rise_cyc[0] : -1, hs_cyc[3] + 1);
    end

    // ---- backpressure on row 2 ----
    for (int i = 0; i < N; i++) send(rnd_x(), 0);
    found = 0;
    for (int n = 0; n < 300 && !found; n++) begin
      tick();
      found = m_valid && (b_addr == 2);
    end
    check("bp_reached_row2", int'(found), 1);
    m_ready = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_m_valid", int'(m_valid), 1);
      check("bp_w_addr", int'(w_addr), 2 * N + N - 1);
      check("bp_b_addr", int'(b_addr), 2);
      check("bp_no_strobe", int'(acc_load | acc_en), 0);
      tick();
    end
    m_ready = 1;
    @(negedge clk);
    tick();
    @(negedge clk);
    check("bp_row3_issue_w", int'(w_addr), 3 * N);
    check("bp_row3_busy", int'(busy && !m_valid), 1);
    tick();
    wait_idle();

    // ---- random vectors with random m_ready and gaps ----
    fork
      begin
        for (int v = 0; v < 4; v++)
          for (int i = 0; i < N; i++) send(rnd_x(), int'($urandom_range(0, 2)));
      end
      begin
        for (int n = 0; n < 400; n++) begin
          tick();
          m_ready = $urandom_range(0, 1) == 1;
        end
      end
    join
    m_ready = 1;
    wait_idle();
    check("rand_y_drained", exp_y.size(), 0);

    // ---- reset during ISSUE of row 1 ----
    do_reset();
    for (int i = 0; i < N; i++) send(rnd_x(), 0);
    found = 0;
    for (int n = 0; n < 300 && !found; n++) begin
      tick();
      found = busy && (b_addr == 1) && (w_addr == WAW'(N + 4));
    end
    check("rr_reached_row1", int'(found), 1);
    check("rr_acc_en_before", int'(acc_en), 1);
    reset = 1;
    #1;
    check("rr_m_valid", int'(m_valid), 0);
    check("rr_acc_en", int'(acc_en), 0);
    check("rr_s_ready", int'(s_ready), 1);
    check("rr_busy", int'(busy), 0);
    @(negedge clk);
    tick();
    reset = 0;
    for (int i = 0; i < N; i++) send(rnd_x(), 0);
    wait_idle();
    check("rr_hs_count", hs_rows.size(), 4);
    if (hs_rows.size() == 4) begin
      for (int r = 0; r < 4; r++) check("rr_row_order", hs_rows[r], r);
      check("rr_bank0", hs_banks[0], 0);
    end

    // ---- gapped input ----
    do_reset();
    npulse = 0;
    for (int i = 0; i < 16; i++) begin
      s_valid = (i % 2 == 0);
      s_data = rnd_x();
      @(negedge clk);
      if (x_wr_en) begin
        check("gap_wr_addr", int'(x_wr_addr), npulse);
        npulse++;
      end
      check("gap_not_busy", int'(busy), 0);
      tick();
    end
    s_valid = 0;
    check("gap_pulses", npulse, 8);
    @(negedge clk);
    check("gap_busy_starts", int'(busy), 1);
    tick();
    wait_idle();
    check("gap_y_drained", exp_y.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mvm_pingpong_sequencer.md
Name: mvm_pingpong_sequencer

Overview:
- Control-only sequencer for one shared single-MAC matrix-vector datapath: ping-pong x buffer, weight ROM, bias ROM, multiplier register, accumulator, ReLU output register.
- Computes y[r] = max(0, B[r] + sum over c of W[r*N+c]·x[c]) for r = 0..M-1 and streams y out over valid/ready.
- Double-buffers input vectors: vector k+1 loads into one bank while vector k is computed from the other.
- Sits between the upstream layer's m_valid/m_ready stream and this layer's datapath; drives addresses and strobes only, no data.

Parameters:
- M, 4, output rows per vector
- N, 8, input elements per vector
- RD_LAT, 2, cycles from issuing x/W addresses to the product arriving at the accumulator (ROM register + multiplier register)
- AW_X = $clog2(N)+1, derived, x buffer address width (MSB = bank)

Ports:
- clk, in, 1, clock
- reset, in, 1, asynchronous active-high reset
- s_valid, in, 1, upstream element valid
- s_ready, out, 1, element accepted when s_valid && s_ready
- x_wr_en, out, 1, x buffer write strobe (combinational = s_valid && s_ready)
- x_wr_addr, out, AW_X, {wr_bank, wr_ptr}
- x_rd_addr, out, AW_X, {rd_bank, col}
- w_addr, out, $clog2(M*N), row*N + col
- b_addr, out, $clog2(M), current row
- acc_load, out, 1, datapath sets acc <= B + product
- acc_en, out, 1, datapath sets acc <= acc + product
- out_latch, out, 1, datapath captures max(acc,0) into its output register
- m_valid, out, 1, output element valid
- m_ready, in, 1, downstream ready
- busy, out, 1, compute FSM not in IDLE

Behaviour:
- Reset (asynchronous, effective immediately):
  - bank_full = 2'b00, wr_bank = rd_bank = 0, wr_ptr = row = col = 0.
  - FSM = IDLE; delay line cleared.
  - Outputs: m_valid, acc_load, acc_en, out_latch and busy = 0. s_ready = 1, derived from the cleared state.
  - Reset mid-operation discards both banks and any partial row.
- Load side:
  - s_ready = !bank_full[wr_bank].
  - On accept: wr_ptr++. When wr_ptr == N-1: set bank_full[wr_bank], toggle wr_bank, wr_ptr <= 0.
- Compute FSM: IDLE -> ISSUE -> DRAIN -> LATCH -> OUT.
  - IDLE: if bank_full[rd_bank], then row <= 0, col <= 0, go to ISSUE.
  - ISSUE (N cycles): drive x_rd_addr and w_addr for the current col, push {valid=1, first=(col==0)} into the RD_LAT-deep delay line, col++. At col == N-1 go to DRAIN.
  - DRAIN (RD_LAT cycles): push bubbles into the delay line.
  - LATCH (1 cycle): out_latch = 1.
  - OUT: m_valid = 1, held until m_ready.
    - On handshake with row == M-1: clear bank_full[rd_bank], toggle rd_bank, go to IDLE.
    - Otherwise: row++, col <= 0, go to ISSUE.
  - b_addr = row, stable from ISSUE entry through LATCH.
- Delay line output drives the accumulator strobes: acc_load = valid && first; acc_en = valid && !first. The two are never both 1.
- Timing (cycle 0 = cycle the N-th element is accepted):
  - Cycle 1: IDLE.
  - Cycles 2..N+1: ISSUE.
  - Then RD_LAT cycles of DRAIN, then 1 cycle of LATCH.
  - m_valid first high at cycle N+RD_LAT+3; 13 for the defaults.
  - With m_ready held high, one row takes N+RD_LAT+2 cycles (12 for the defaults).
- Boundaries:
  - Both banks full: s_ready = 0 until the compute side frees a bank; s_ready returns high the cycle after the final-row handshake.
  - A bank release and a bank fill in the same cycle hit different banks by construction; both take effect.
  - m_ready low: FSM holds in OUT. Addresses and b_addr hold, no strobes are issued.
  - Input arriving while busy fills the other bank; it never stalls compute.
- Widths: counters wrap only via the explicit compares above; w_addr never exceeds M*N-1.

Decomposition:
- Package mvm_seq_pkg:
  - state enum {IDLE, ISSUE, DRAIN, LATCH, OUT}
  - localparams for derived widths
  - struct issue_tag_t {valid, first}
- One sub-module, mvm_issue_delay: parameterised RD_LAT-stage shift register of issue_tag_t with async reset.

Test Plan:
- Single vector, m_ready = 1:
  - Feed 8 elements back-to-back.
  - Expect w_addr sequence 0..7 and acc_load at cycle 4, acc_en at cycles 5..11.
  - Expect out_latch at cycle 12, m_valid at 13, four outputs spaced 12 cycles apart.
  - Final handshake occurs at cycle 49.
- Ping-pong: stream 24 elements with s_valid held high.
  - s_ready drops after the 16th element (both banks full).
  - s_ready rises the cycle after the 4th output handshake of vector 0.
  - x_rd_addr MSB alternates 0, 1, 0.
- Backpressure: hold m_ready = 0 for 5 cycles on row 2.
  - m_valid stays 1 and w_addr/b_addr stay stable; no acc strobes.
  - Row 3 ISSUE starts the cycle after the handshake.
- Reset mid-row: assert reset during ISSUE of row 1.
  - Same cycle: m_valid = 0, acc_en = 0, s_ready = 1.
  - A fresh vector afterwards produces outputs for rows 0..3 in order, using bank 0.
- Gapped input: s_valid toggling 1/0 over 16 cycles.
  - Exactly 8 x_wr_en pulses with x_wr_addr 0..7.
  - Compute starts only after the 8th pulse.
- End-to-end with a datapath model and the team's 4x8 weight/bias ROM contents:
  - x = all 1 gives y = max(0, row sums + bias).
  - Check one negative row clamps to 0.
